// File: rtl/irq_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : irq_sequencer_pkg
// Purpose  : Shared constants for the interrupt service sequencer:
//            irq code values, FSM state encoding and a code normaliser.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package irq_sequencer_pkg;

  // Interrupt codes as delivered by the prioritiser
  localparam logic [1:0] IRQ_NONE = 2'b00;
  localparam logic [1:0] IRQ_WARN = 2'b01;
  localparam logic [1:0] IRQ_EMER = 2'b10;

  // Service FSM state encoding
  localparam int         ST_W       = 3;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PRESENT = 3'd1;
  localparam logic [2:0] ST_SERVICE = 3'd2;
  localparam logic [2:0] ST_ACK     = 3'd3;
  localparam logic [2:0] ST_HOLDOFF = 3'd4;

  // Code 11 is an emergency; fold it onto 10 so the host only sees 01/10.
  function automatic logic [1:0] norm_code(input logic [1:0] code);
    return code[1] ? IRQ_EMER : code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Event counter that sticks at its all-ones value.
// Ports    : clk   - clock, rising edge
//            rst   - asynchronous active-low reset
//            inc   - count one event
//            clear - synchronous clear (wins over inc)
//            count - current count
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/irq_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : irq_sequencer
// Purpose  : Service controller for the interrupt prioritiser. Latches the
//            irq code, presents it to the host (valid/ready), waits for
//            host_done, pulses irq_ack, then masks warn for a holdoff window.
//            Includes a service watchdog, sticky alarm and event counters.
// Ports    : clk, rst (async active-low)
//            irq/irq_ack/irq_mask        - prioritiser side
//            cfg_we/cfg_mask             - software mask write
//            host_valid/host_code/host_ready/host_done - host side
//            timeout/alarm/alarm_clr     - watchdog
//            busy, warn_cnt, emer_cnt    - status
// Revision : 1.0 - initial release
// ============================================================================
module irq_sequencer
  import irq_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 1000,
  parameter int TMR_W   = 16,
  parameter int HOLDOFF = 8,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       irq,
  output logic             irq_ack,
  output logic [1:0]       irq_mask,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_mask,
  output logic             host_valid,
  output logic [1:0]       host_code,
  input  logic             host_ready,
  input  logic             host_done,
  output logic             timeout,
  output logic             alarm,
  input  logic             alarm_clr,
  output logic             busy,
  output logic [CNT_W-1:0] warn_cnt,
  output logic [CNT_W-1:0] emer_cnt
);

  localparam int HLD_W = $clog2(HOLDOFF + 1);

  logic [ST_W-1:0]  r_state;
  logic [ST_W-1:0]  w_next;
  logic [1:0]       r_code;
  logic [1:0]       r_sw_mask;
  logic [TMR_W-1:0] r_timer;
  logic [HLD_W-1:0] r_hold;
  logic             r_alarm;
  logic             r_timeout;

  logic w_active;
  logic w_start;
  logic w_preempt;
  logic w_done;
  logic w_expire;
  logic w_hold_end;

  assign w_active   = (r_state == ST_PRESENT) || (r_state == ST_SERVICE);
  assign w_start    = (r_state == ST_IDLE) && (irq != IRQ_NONE);
  // An emergency arriving while a warn is outstanding replaces it.
  assign w_preempt  = w_active && (r_code == IRQ_WARN) && irq[1];
  assign w_done     = (r_state == ST_SERVICE) && host_done;
  // Completion in the last allowed cycle beats the watchdog.
  assign w_expire   = w_active && !w_preempt && !w_done &&
                      (r_timer == TMR_W'(TIMEOUT - 1));
  assign w_hold_end = (r_hold == HLD_W'(HOLDOFF - 1));

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_next = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (w_preempt)       w_next = ST_PRESENT;
        else if (w_expire)   w_next = ST_ACK;
        else if (host_ready) w_next = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (w_preempt)                w_next = ST_PRESENT;
        else if (w_done || w_expire)  w_next = ST_ACK;
      end
      ST_ACK: begin
        w_next = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (w_hold_end) w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (decoded from registers only)
  // --------------------------------------------------------------------------
  always_comb begin
    host_valid = (r_state == ST_PRESENT);
    irq_ack    = (r_state == ST_ACK);
    busy       = (r_state != ST_IDLE);
    // Warn is level-sensitive: keep it masked until the prioritiser has
    // dropped the serviced code.
    irq_mask   = (r_state == ST_HOLDOFF) ? (r_sw_mask | IRQ_WARN) : r_sw_mask;
  end

  assign host_code = r_code;
  assign timeout   = r_timeout;
  assign alarm     = r_alarm;

  // --------------------------------------------------------------------------
  // Datapath: code latch, watchdog timer, holdoff count, alarm, sw mask
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_code    <= IRQ_NONE;
      r_sw_mask <= 2'b00;
      r_timer   <= '0;
      r_hold    <= '0;
      r_alarm   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_expire;

      // Set has priority over clear.
      if (w_expire && (r_code == IRQ_EMER)) begin
        r_alarm <= 1'b1;
      end else if (alarm_clr) begin
        r_alarm <= 1'b0;
      end

      if (cfg_we) begin
        r_sw_mask <= cfg_mask;
      end

      if (w_start) begin
        r_code  <= norm_code(irq);
        r_timer <= '0;
      end else if (w_preempt) begin
        r_code  <= IRQ_EMER;
        r_timer <= '0;
      end else if (w_active) begin
        r_timer <= r_timer + 1'b1;
      end

      if (r_state == ST_HOLDOFF) begin
        r_hold <= r_hold + 1'b1;
      end else begin
        r_hold <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Event counters
  // --------------------------------------------------------------------------
  logic w_warn_inc;
  logic w_emer_inc;

  assign w_warn_inc = w_start && (irq == IRQ_WARN);
  assign w_emer_inc = (w_start && irq[1]) || w_preempt;

  sat_counter #(.CNT_W(CNT_W)) u_warn_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_warn_inc),
    .clear (1'b0),
    .count (warn_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_emer_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_emer_inc),
    .clear (1'b0),
    .count (emer_cnt)
  );

endmodule
`default_nettype wire
